// File: rtl/axi4_lite_reg_cfg_sequencer_if.sv
`default_nettype none
// ------------------------------------------------------------------
// ifc_axi4_lite : AXI4-lite bus bundle with master/slave views.
// Rev 1.0
// ------------------------------------------------------------------
interface ifc_axi4_lite #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface
`default_nettype wire

// File: rtl/axi4_lite_reg_cfg_sequencer.sv
`default_nettype none
// ------------------------------------------------------------------
// axi4_lite_reg_cfg_sequencer : replays a register write table over
// AXI4-lite with optional read-back check.   Rev 1.0
// ------------------------------------------------------------------
module axi4_lite_reg_cfg_sequencer #(
  parameter int unsigned               AXI_ADDR_WIDTH = 32,
  parameter int unsigned               AXI_DATA_WIDTH = 32,
  parameter logic [AXI_ADDR_WIDTH-1:0] AXI_BASE_ADDR  = '0,
  parameter int unsigned               NUM_ENTRIES    = 8,
  parameter int unsigned               TIMEOUT_CYCLES = 256,
  localparam int unsigned              CNT_W = $clog2(NUM_ENTRIES + 1),
  localparam int unsigned              IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  ifc_axi4_lite.master              if_axi,
  input  logic                      i_start,
  input  logic [CNT_W-1:0]          i_num_entries,
  input  logic [AXI_ADDR_WIDTH-1:0] i_cfg_addr [NUM_ENTRIES],
  input  logic [AXI_DATA_WIDTH-1:0] i_cfg_data [NUM_ENTRIES],
  input  logic [NUM_ENTRIES-1:0]    i_cfg_verify,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_error,
  output logic [IDX_W-1:0]          o_err_index,
  output logic [1:0]                o_err_code
);
  localparam int unsigned      TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] NUM_MAX  = CNT_W'(NUM_ENTRIES);
  localparam logic [1:0]       ERR_RESP   = 2'b01;
  localparam logic [1:0]       ERR_VERIFY = 2'b10;
  localparam logic [1:0]       ERR_TMO    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_RESP = 3'd4,
    S_NEXT    = 3'd5,
    S_ERROR   = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [1:0]       pend_code_q, pend_code_d;
  logic             awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic             bready_q, bready_d, arvalid_q, arvalid_d, rready_q, rready_d;
  logic             busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [IDX_W-1:0] err_index_q, err_index_d;
  logic [1:0]       err_code_q, err_code_d;

  logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_last, w_tmo;

  assign w_aw_hs = awvalid_q & if_axi.awready;
  assign w_w_hs  = wvalid_q & if_axi.wready;
  assign w_b_hs  = bready_q & if_axi.bvalid;
  assign w_ar_hs = arvalid_q & if_axi.arready;
  assign w_r_hs  = rready_q & if_axi.rvalid;
  assign w_last  = (CNT_W'(idx_q) + CNT_W'(1)) == num_q;
  assign w_tmo   = (tmo_q == TMO_LAST);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    num_d       = num_q;
    tmo_d       = tmo_q;
    pend_code_d = pend_code_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    done_d      = 1'b0;
    error_d     = error_q;
    err_index_d = err_index_q;
    err_code_d  = err_code_q;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          error_d     = 1'b0;
          err_index_d = '0;
          err_code_d  = 2'b00;
          idx_d       = '0;
          if (i_num_entries == '0) begin
            done_d = 1'b1;
          end else begin
            num_d     = (i_num_entries > NUM_MAX) ? NUM_MAX : i_num_entries;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WR_REQ;
          end
        end
      end
      S_WR_REQ: begin
        if (w_aw_hs) awvalid_d = 1'b0;
        if (w_w_hs)  wvalid_d  = 1'b0;
        // Either channel may have completed on an earlier cycle.
        if ((w_aw_hs || !awvalid_q) && (w_w_hs || !wvalid_q)) begin
          bready_d = 1'b1;
          tmo_d    = '0;
          state_d  = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        if (w_b_hs) begin
          bready_d = 1'b0;
          if (if_axi.bresp != 2'b00) begin
            pend_code_d = ERR_RESP;
            state_d     = S_ERROR;
          end else if (i_cfg_verify[idx_q]) begin
            arvalid_d = 1'b1;
            state_d   = S_RD_REQ;
          end else begin
            state_d = S_NEXT;
          end
        end else if (w_tmo) begin
          bready_d    = 1'b0;
          pend_code_d = ERR_TMO;
          state_d     = S_ERROR;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_RD_REQ: begin
        if (w_ar_hs) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          tmo_d     = '0;
          state_d   = S_RD_RESP;
        end
      end
      S_RD_RESP: begin
        if (w_r_hs) begin
          rready_d = 1'b0;
          if (if_axi.rresp != 2'b00) begin
            pend_code_d = ERR_RESP;
            state_d     = S_ERROR;
          end else if (if_axi.rdata != i_cfg_data[idx_q]) begin
            pend_code_d = ERR_VERIFY;
            state_d     = S_ERROR;
          end else begin
            state_d = S_NEXT;
          end
        end else if (w_tmo) begin
          rready_d    = 1'b0;
          pend_code_d = ERR_TMO;
          state_d     = S_ERROR;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_NEXT: begin
        if (w_last) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          idx_d     = idx_q + IDX_W'(1);
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = S_WR_REQ;
        end
      end
      S_ERROR: begin
        error_d     = 1'b1;
        err_index_d = idx_q;
        err_code_d  = pend_code_q;
        bready_d    = 1'b0;
        rready_d    = 1'b0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      num_q       <= '0;
      tmo_q       <= '0;
      pend_code_q <= 2'b00;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_index_q <= '0;
      err_code_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      num_q       <= num_d;
      tmo_q       <= tmo_d;
      pend_code_q <= pend_code_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_index_q <= err_index_d;
      err_code_q  <= err_code_d;
    end
  end

  // Address/data follow the live table entry; the table is held stable while busy.
  assign if_axi.awaddr  = AXI_BASE_ADDR + i_cfg_addr[idx_q];
  assign if_axi.awprot  = 3'b000;
  assign if_axi.awvalid = awvalid_q;
  assign if_axi.wdata   = i_cfg_data[idx_q];
  assign if_axi.wstrb   = '1;
  assign if_axi.wvalid  = wvalid_q;
  assign if_axi.bready  = bready_q;
  assign if_axi.araddr  = AXI_BASE_ADDR + i_cfg_addr[idx_q];
  assign if_axi.arprot  = 3'b000;
  assign if_axi.arvalid = arvalid_q;
  assign if_axi.rready  = rready_q;

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_error     = error_q;
  assign o_err_index = err_index_q;
  assign o_err_code  = err_code_q;
endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_reg_cfg_sequencer.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_axi4_lite_reg_cfg_sequencer : randomised AXI4-lite slave, table
// level reference model and queue scoreboard.   Rev 1.0
// ------------------------------------------------------------------
module tb_axi4_lite_reg_cfg_sequencer;
  localparam int          NE   = 8;
  localparam int          TMO  = 16;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  num   = '0;
  logic [31:0] cfg_addr [NE];
  logic [31:0] cfg_data [NE];
  logic [NE-1:0] cfg_verify = '0;
  logic        busy, done, error;
  logic [2:0]  err_index;
  logic [1:0]  err_code;

  ifc_axi4_lite #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

  axi4_lite_reg_cfg_sequencer #(
    .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_BASE_ADDR(BASE),
    .NUM_ENTRIES(NE), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .if_axi(axi), .i_start(start),
    .i_num_entries(num), .i_cfg_addr(cfg_addr), .i_cfg_data(cfg_data),
    .i_cfg_verify(cfg_verify), .o_busy(busy), .o_done(done), .o_error(error),
    .o_err_index(err_index), .o_err_code(err_code)
  );

  initial forever #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard queues: expected pushed at issue, observed pushed by the slave
  logic [63:0] exp_wr[$], obs_wr[$];
  logic [31:0] exp_rd[$], obs_rd[$];
  logic [5:0]  exp_out[$];
  int          obs_awd[$], obs_wd[$];

  // Slave behaviour: 0 ok, 1 BRESP err, 2 RRESP err, 3 RDATA corrupt, 4 no B, 5 no R
  int  fault [NE];
  bit  zero_wait = 1'b0;
  bit  hold_req  = 1'b0;
  int  fix_aw = -1, fix_w = -1;
  logic [31:0] mem [logic [31:0]];
  bit  aw_got, w_got, b_pend, r_pend;
  bit  aw_fire, w_fire, b_fire, ar_fire, r_fire;
  logic [31:0] cap_addr, cap_data, rd_addr;
  int  wr_cnt, cur_e, aw_wait, w_wait, b_wait, ar_wait, r_wait, aw_dly, w_dly;

  function automatic int pick(input int hi);
    return zero_wait ? 0 : int'($urandom_range(0, hi));
  endfunction

  task automatic new_write_delays();
    aw_dly  = (fix_aw >= 0) ? fix_aw : pick(3);
    w_dly   = (fix_w >= 0) ? fix_w : pick(3);
    aw_wait = aw_dly;
    w_wait  = w_dly;
  endtask

  task automatic slave_clear();
    aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
    aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0;
    wr_cnt = 0; cur_e = 0; b_wait = 0; r_wait = 0; ar_wait = pick(2);
    axi.awready = 0; axi.wready = 0; axi.arready = 0;
    axi.bvalid = 0; axi.rvalid = 0; axi.bresp = 0; axi.rresp = 0; axi.rdata = 0;
    new_write_delays();
  endtask

  // Slave: at each falling edge retire the handshakes of the last rising
  // edge, then drive READY/VALID for the next one.
  initial begin
    slave_clear();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        slave_clear();
      end else begin
        if (aw_fire) begin aw_got = 1; check("awvalid_drops_after_hs", axi.awvalid, 0); end
        if (w_fire)  begin w_got = 1;  check("wvalid_drops_after_hs", axi.wvalid, 0); end
        if ((aw_fire || w_fire) && aw_got && w_got) begin
          obs_wr.push_back({cap_addr, cap_data});
          obs_awd.push_back(aw_dly);
          obs_wd.push_back(w_dly);
          mem[cap_addr] = cap_data;
          cur_e  = wr_cnt;
          wr_cnt = wr_cnt + 1;
          b_pend = (fault[cur_e % NE] != 4);
          b_wait = pick(2);
        end
        if (b_fire) begin axi.bvalid = 0; aw_got = 0; w_got = 0; new_write_delays(); end
        if (ar_fire) begin
          obs_rd.push_back(rd_addr);
          r_pend = (fault[cur_e % NE] != 5);
          r_wait = pick(2);
        end
        if (r_fire) begin axi.rvalid = 0; ar_wait = pick(2); end

        axi.awready = 0;
        if (axi.awvalid && !aw_got && !hold_req) begin
          if (aw_wait > 0) aw_wait--; else axi.awready = 1;
        end
        axi.wready = 0;
        if (axi.wvalid && !w_got && !hold_req) begin
          if (w_wait > 0) w_wait--; else axi.wready = 1;
        end
        if (b_pend && !axi.bvalid) begin
          if (b_wait > 0) b_wait--;
          else begin
            axi.bvalid = 1;
            axi.bresp  = (fault[cur_e % NE] == 1) ? (cur_e[0] ? 2'b11 : 2'b10) : 2'b00;
            b_pend = 0;
          end
        end
        axi.arready = 0;
        if (axi.arvalid && !r_pend && !axi.rvalid) begin
          if (ar_wait > 0) ar_wait--; else axi.arready = 1;
        end
        if (r_pend && !axi.rvalid) begin
          if (r_wait > 0) r_wait--;
          else begin
            axi.rvalid = 1;
            axi.rdata  = mem.exists(rd_addr) ? mem[rd_addr] : 32'h0;
            if (fault[cur_e % NE] == 3) axi.rdata = axi.rdata ^ 32'h1;
            axi.rresp  = (fault[cur_e % NE] == 2) ? 2'b10 : 2'b00;
            r_pend = 0;
          end
        end

        aw_fire = axi.awvalid && axi.awready;
        w_fire  = axi.wvalid && axi.wready;
        b_fire  = axi.bvalid && axi.bready;
        ar_fire = axi.arvalid && axi.arready;
        r_fire  = axi.rvalid && axi.rready;
        if (aw_fire) begin cap_addr = axi.awaddr; check("awprot", axi.awprot, 0); end
        if (w_fire)  begin cap_data = axi.wdata;  check("wstrb", axi.wstrb, 4'hF); end
        if (ar_fire) rd_addr = axi.araddr;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a transaction or outcome
  initial begin
    int aw_hi, w_hi, rdy_run, last_wait, ad, wd;
    logic prev_done, prev_err;
    logic [63:0] o;
    logic [31:0] ra;
    logic [5:0] got, e;
    aw_hi = 0; w_hi = 0; rdy_run = 0; last_wait = 0; prev_done = 0; prev_err = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        aw_hi = 0; w_hi = 0; rdy_run = 0; prev_done = 0; prev_err = 0;
      end else begin
        while (obs_wr.size() > 0) begin
          o  = obs_wr.pop_front();
          ad = obs_awd.pop_front();
          wd = obs_wd.pop_front();
          check("write_expected", exp_wr.size() > 0, 1);
          if (exp_wr.size() > 0) check("write_addr_data", o, exp_wr.pop_front());
          check("awvalid_cycles", aw_hi, ad + 1);
          check("wvalid_cycles", w_hi, wd + 1);
          aw_hi = 0; w_hi = 0;
        end
        while (obs_rd.size() > 0) begin
          ra = obs_rd.pop_front();
          check("read_expected", exp_rd.size() > 0, 1);
          if (exp_rd.size() > 0) check("araddr", ra, exp_rd.pop_front());
        end
        if (axi.awvalid) aw_hi++;
        if (axi.wvalid)  w_hi++;
        if (axi.bready || axi.rready) rdy_run++;
        else begin
          if (rdy_run > 0) last_wait = rdy_run;
          rdy_run = 0;
        end
        if (done) check("done_single_cycle", prev_done, 0);
        if (done || (error && !prev_err)) begin
          got = done ? 6'b0 : {1'b1, err_code, err_index};
          check("outcome_expected", exp_out.size() > 0, 1);
          if (exp_out.size() > 0) begin
            e = exp_out.pop_front();
            check("outcome", got, e);
            if (e[4:3] == 2'b11) begin
              check("timeout_cycles", last_wait, TMO);
              check("ready_low_after_error", {axi.bready, axi.rready}, 0);
            end
          end
        end
        prev_done = done;
        prev_err  = error;
      end
    end
  end

  // Reference model at table level, then start and wait for the outcome
  task automatic run_seq(input int n_req, input bit chk_lat);
    int n, lat, c;
    bit failed;
    logic [1:0] code;
    n = (n_req > NE) ? NE : n_req;
    lat = 1; failed = 0; code = 2'b00;
    slave_clear();
    mem.delete();
    for (int e = 0; e < n && !failed; e++) begin
      exp_wr.push_back({BASE + cfg_addr[e], cfg_data[e]});
      lat += 3;
      if (fault[e] == 1 || fault[e] == 4) begin
        code = (fault[e] == 1) ? 2'b01 : 2'b11;
        exp_out.push_back({1'b1, code, 3'(e)});
        failed = 1;
      end else if (cfg_verify[e]) begin
        exp_rd.push_back(BASE + cfg_addr[e]);
        lat += 2;
        if (fault[e] >= 2) begin
          code = (fault[e] == 2) ? 2'b01 : (fault[e] == 3) ? 2'b10 : 2'b11;
          exp_out.push_back({1'b1, code, 3'(e)});
          failed = 1;
        end
      end
    end
    if (!failed) exp_out.push_back(6'b0);

    num = 4'(n_req);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    c = 1;
    check("error_cleared_on_start", error, 0);
    check("busy_after_start", busy, (n > 0));
    if (n > 0 && $urandom_range(0, 1) == 1) begin
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      c++;
    end
    while (!done && !error && c < 2000) begin
      @(posedge clk); #1;
      c++;
    end
    check("sequence_finished", done | error, 1);
    if (chk_lat && !failed) check("done_latency", c, lat);
    repeat (20) @(posedge clk);
    #1;
    check("writes_drained", exp_wr.size(), 0);
    check("reads_drained", exp_rd.size(), 0);
    check("outcome_drained", exp_out.size(), 0);
    check("idle_after_run", {busy, axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 0);
    exp_wr.delete(); exp_rd.delete(); exp_out.delete();
  endtask

  task automatic clear_table();
    for (int i = 0; i < NE; i++) begin
      fault[i] = 0; cfg_addr[i] = 32'(4 * i); cfg_data[i] = 32'(i);
    end
    cfg_verify = '0;
  endtask

  initial begin
    clear_table();
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {busy, done, error, err_index, err_code, axi.awvalid,
                          axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 0);
    rst_n = 1'b1;

    // 3-entry write-only run with a zero-wait slave
    zero_wait = 1;
    cfg_addr[0] = 32'h0; cfg_addr[1] = 32'h4; cfg_addr[2] = 32'h8;
    cfg_data[0] = 32'hA5; cfg_data[1] = 32'h5A; cfg_data[2] = 32'hFF;
    run_seq(3, 1);

    // Verify on entry 1 with slave returning 0x5B
    cfg_verify = 8'b0000_0010;
    fault[1] = 3;
    run_seq(3, 1);
    fault[1] = 0; cfg_verify = '0;

    // AWREADY delayed 3 cycles, WREADY immediate
    fix_aw = 3; fix_w = 0;
    run_seq(2, 0);
    fix_aw = -1; fix_w = -1;

    // No BVALID ever: timeout
    fault[0] = 4;
    run_seq(3, 0);

    // SLVERR on entry 0, then a clean replay
    fault[0] = 1;
    run_seq(3, 0);
    fault[0] = 0;
    cfg_verify = 8'b0000_0101;
    run_seq(3, 1);

    // Zero entries and clamped count
    run_seq(0, 1);
    run_seq(12, 1);

    // Reset during WR_REQ
    hold_req = 1;
    num = 4'd2;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    check("wr_req_before_reset", {busy, axi.awvalid, axi.wvalid}, 3'b111);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("reset_mid_sequence", {busy, axi.awvalid, axi.wvalid, done, error}, 0);
    rst_n = 1'b1;
    hold_req = 0;
    repeat (2) @(posedge clk);
    run_seq(2, 1);

    // Randomised tables, delays and faults
    for (int r = 0; r < 40; r++) begin
      zero_wait = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < NE; i++) begin
        cfg_addr[i] = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        cfg_data[i] = $urandom;
        fault[i]    = ($urandom_range(0, 19) < 16) ? 0 : int'($urandom_range(1, 5));
      end
      cfg_verify = 8'($urandom);
      run_seq(int'($urandom_range(0, 10)), zero_wait);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
